// File: rtl/seq_pattern_detector_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package seq_pattern_detector_pkg;

  localparam int unsigned MAX_VEC_W = 256;
  localparam int unsigned MAX_PAT_W = 32;

  localparam bit MODE_NON_OVERLAP = 1'b0;
  localparam bit MODE_OVERLAP     = 1'b1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    if (value > 1) begin
      for (int unsigned v = value - 1; v > 0; v = v >> 1) r++;
    end
    return r;
  endfunction

  // Pattern k of a packed vector of len-bit patterns, zero-extended.
  function automatic logic [MAX_PAT_W-1:0] pat_slice(input logic [MAX_VEC_W-1:0] vec,
                                                     input int unsigned k,
                                                     input int unsigned len);
    logic [MAX_PAT_W-1:0] mask;
    mask = (len >= MAX_PAT_W) ? '1 : ((MAX_PAT_W'(1) << len) - MAX_PAT_W'(1));
    return MAX_PAT_W'(vec >> (k * len)) & mask;
  endfunction

endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/seq_pattern_detector.sv
// Multi-pattern serial detector with fill tracking, overlap mode and per-pattern hit counters.
module seq_pattern_detector
  import seq_pattern_detector_pkg::*;
#(
  parameter int unsigned                PAT_LEN = 3,
  parameter int unsigned                NUM_PAT = 2,
  parameter logic [PAT_LEN*NUM_PAT-1:0] PAT_VEC = {3'b111, 3'b001},
  parameter bit                         OVERLAP = MODE_OVERLAP,
  parameter int unsigned                CNT_W   = 8,
  localparam int unsigned               FILL_W  = clog2(PAT_LEN + 1)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     i,
  output logic [NUM_PAT-1:0]       o,
  output logic                     any_match,
  output logic [NUM_PAT*CNT_W-1:0] hit_cnt,
  output logic [FILL_W-1:0]        fill
);

  localparam int unsigned       HIST_W    = PAT_LEN - 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN - 1);

  logic [HIST_W-1:0]  r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic [NUM_PAT-1:0] r_o;
  logic               r_any;

  logic [PAT_LEN-1:0] w_window;
  logic               w_full;
  logic [NUM_PAT-1:0] w_match;
  logic               w_any;

  assign w_window = {r_hist, i};
  assign w_full   = (r_fill == FILL_FULL);
  assign w_any    = |w_match;

  for (genvar k = 0; k < NUM_PAT; k++) begin : g_pat
    localparam logic [PAT_LEN-1:0] PAT_K = PAT_LEN'(pat_slice(MAX_VEC_W'(PAT_VEC), k, PAT_LEN));

    // Only a full history window may match; en/clr gate it here so counters see the same pulse.
    assign w_match[k] = en & ~clr & w_full & (w_window == PAT_K);

    sat_counter #(
      .W(CNT_W)
    ) u_cnt (
      .clock  (clock),
      .reset_n(reset_n),
      .clr    (clr),
      .inc    (w_match[k]),
      .count  (hit_cnt[k*CNT_W +: CNT_W])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hist <= '0;
      r_fill <= '0;
      r_o    <= '0;
      r_any  <= 1'b0;
    end else if (clr) begin
      r_hist <= '0;
      r_fill <= '0;
      r_o    <= '0;
      r_any  <= 1'b0;
    end else if (en) begin
      r_hist <= w_window[HIST_W-1:0];
      if (w_any && (OVERLAP == MODE_NON_OVERLAP)) begin
        r_fill <= '0;
      end else if (!w_full) begin
        r_fill <= r_fill + FILL_W'(1);
      end
      r_o   <= w_match;
      r_any <= w_any;
    end else begin
      r_o   <= '0;
      r_any <= 1'b0;
    end
  end

  assign o         = r_o;
  assign any_match = r_any;
  assign fill      = r_fill;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: four configurations driven by one stream, checked against a queue model.
module tb_seq_pattern_detector;

  localparam int unsigned PL  = 3;
  localparam int unsigned NC  = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic en;
  logic clr;
  logic din;

  always #5 clk = ~clk;

  logic [1:0]  o_0, o_1, o_2, o_3;
  logic        any_0, any_1, any_2, any_3;
  logic [15:0] hc_0, hc_1, hc_3;
  logic [3:0]  hc_2;
  logic [1:0]  fill_0, fill_1, fill_2, fill_3;

  seq_pattern_detector u_dut_ovl (
    .clock(clk), .reset_n(reset_n), .en(en), .clr(clr), .i(din),
    .o(o_0), .any_match(any_0), .hit_cnt(hc_0), .fill(fill_0)
  );

  seq_pattern_detector #(.OVERLAP(1'b0)) u_dut_novl (
    .clock(clk), .reset_n(reset_n), .en(en), .clr(clr), .i(din),
    .o(o_1), .any_match(any_1), .hit_cnt(hc_1), .fill(fill_1)
  );

  seq_pattern_detector #(.CNT_W(2)) u_dut_c2 (
    .clock(clk), .reset_n(reset_n), .en(en), .clr(clr), .i(din),
    .o(o_2), .any_match(any_2), .hit_cnt(hc_2), .fill(fill_2)
  );

  seq_pattern_detector #(.PAT_VEC(6'b001001)) u_dut_dup (
    .clock(clk), .reset_n(reset_n), .en(en), .clr(clr), .i(din),
    .o(o_3), .any_match(any_3), .hit_cnt(hc_3), .fill(fill_3)
  );

  logic [1:0] obs_o    [NC];
  logic       obs_any  [NC];
  logic [1:0] obs_fill [NC];
  logic [7:0] obs_cnt  [NC][2];

  assign obs_o[0] = o_0;  assign obs_any[0] = any_0;  assign obs_fill[0] = fill_0;
  assign obs_o[1] = o_1;  assign obs_any[1] = any_1;  assign obs_fill[1] = fill_1;
  assign obs_o[2] = o_2;  assign obs_any[2] = any_2;  assign obs_fill[2] = fill_2;
  assign obs_o[3] = o_3;  assign obs_any[3] = any_3;  assign obs_fill[3] = fill_3;
  assign obs_cnt[0][0] = hc_0[7:0];  assign obs_cnt[0][1] = hc_0[15:8];
  assign obs_cnt[1][0] = hc_1[7:0];  assign obs_cnt[1][1] = hc_1[15:8];
  assign obs_cnt[2][0] = {6'd0, hc_2[1:0]};  assign obs_cnt[2][1] = {6'd0, hc_2[3:2]};
  assign obs_cnt[3][0] = hc_3[7:0];  assign obs_cnt[3][1] = hc_3[15:8];

  // Reference model: each configuration keeps the last valid bits in a queue (oldest first).
  int unsigned pats    [NC][2];
  bit          ovl     [NC];
  int unsigned cmax    [NC];
  bit          mq      [NC][$];
  bit   [1:0]  exp_o   [NC];
  int unsigned exp_cnt [NC][2];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      mq[c].delete();
      exp_o[c] = 2'b00;
      exp_cnt[c][0] = 0;
      exp_cnt[c][1] = 0;
    end
  endtask

  task automatic model_edge(input bit m_en, input bit m_clr, input bit m_i);
    int unsigned win;
    for (int c = 0; c < NC; c++) begin
      exp_o[c] = 2'b00;
      if (m_clr) begin
        mq[c].delete();
        exp_cnt[c][0] = 0;
        exp_cnt[c][1] = 0;
      end else if (m_en) begin
        if (mq[c].size() == PL - 1) begin
          win = 0;
          for (int j = 0; j < mq[c].size(); j++) win = win * 2 + int'(mq[c][j]);
          win = win * 2 + int'(m_i);
          for (int k = 0; k < 2; k++) begin
            if (win == pats[c][k]) begin
              exp_o[c][k] = 1'b1;
              if (exp_cnt[c][k] < cmax[c]) exp_cnt[c][k]++;
            end
          end
        end
        mq[c].push_back(m_i);
        if (mq[c].size() > PL - 1) void'(mq[c].pop_front());
        if (exp_o[c] != 2'b00 && !ovl[c]) mq[c].delete();
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NC; c++) begin
      check($sformatf("c%0d_o", c), 32'(obs_o[c]), 32'(exp_o[c]));
      check($sformatf("c%0d_any", c), 32'(obs_any[c]), 32'(exp_o[c] != 2'b00));
      check($sformatf("c%0d_fill", c), 32'(obs_fill[c]), 32'(mq[c].size()));
      for (int k = 0; k < 2; k++)
        check($sformatf("c%0d_cnt%0d", c, k), 32'(obs_cnt[c][k]), exp_cnt[c][k]);
    end
  endtask

  // One clock: drive at negedge (also releases any pending reset), update model at posedge, compare after.
  task automatic step(input bit s_en, input bit s_clr, input bit s_i);
    @(negedge clk);
    reset_n = 1'b1;
    en  = s_en;
    clr = s_clr;
    din = s_i;
    @(posedge clk);
    model_edge(s_en, s_clr, s_i);
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    en = 1'b0;
    #1;
    model_reset();
    compare_all();
  endtask

  initial begin
    for (int c = 0; c < NC; c++) begin
      pats[c][0] = 1;
      pats[c][1] = (c == 3) ? 1 : 7;
      ovl[c]     = (c != 1);
      cmax[c]    = (c == 2) ? 3 : 255;
    end
    model_reset();
    reset_n = 1'b0;
    en  = 1'b0;
    clr = 1'b0;
    din = 1'b0;
    #13;
    compare_all();

    // Reset mid-stream discards partial history.
    step(1, 0, 0);
    step(1, 0, 0);
    async_reset();
    check("t1_fill_rst", 32'(fill_0), 32'd0);
    step(1, 0, 1);
    check("t1_no_match", 32'(o_0), 32'd0);

    // Basic 001 match.
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 1);
    check("t2_o", 32'(o_0), 32'd1);
    check("t2_any", 32'(any_0), 32'd1);
    check("t2_cnt0", 32'(hc_0[7:0]), 32'd1);
    check("t2_cnt1", 32'(hc_0[15:8]), 32'd0);
    step(1, 0, 0);
    check("t2_pulse", 32'(o_0), 32'd0);

    // Overlap vs non-overlap on a run of ones.
    step(1, 1, 0);
    for (int n = 0; n < 5; n++) step(1, 0, 1);
    check("t3_ovl_cnt", 32'(hc_0[15:8]), 32'd3);
    check("t3_novl_cnt", 32'(hc_1[15:8]), 32'd1);
    step(1, 0, 1);
    check("t3_novl_o", 32'(o_1), 32'd2);
    check("t3_novl_cnt2", 32'(hc_1[15:8]), 32'd2);

    // Enable gating holds history.
    step(1, 1, 0);
    step(1, 0, 0);
    step(0, 0, 1);
    check("t4_en0_o_a", 32'(o_0), 32'd0);
    step(0, 0, 0);
    check("t4_en0_o_b", 32'(o_0), 32'd0);
    step(1, 0, 0);
    step(1, 0, 1);
    check("t4_match", 32'(o_0), 32'd1);

    // Counter saturation then clear beating a match.
    step(1, 1, 0);
    for (int n = 0; n < 6; n++) begin
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 0, 1);
    end
    check("t5_sat", 32'(hc_2[1:0]), 32'd3);
    check("t5_wide", 32'(hc_0[7:0]), 32'd6);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 1);
    check("t5_clr_o", 32'(o_2), 32'd0);
    check("t5_clr_cnt", 32'(hc_2[1:0]), 32'd0);
    check("t5_clr_fill", 32'(fill_2), 32'd0);

    // Duplicate patterns fire together.
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 1);
    check("t6_o", 32'(o_3), 32'd3);
    check("t6_cnt0", 32'(hc_3[7:0]), 32'd1);
    check("t6_cnt1", 32'(hc_3[15:8]), 32'd1);
    check("t6_any", 32'(any_3), 32'd1);

    // Randomized stream.
    for (int n = 0; n < 1500; n++) begin
      step(bit'($urandom_range(0, 9) != 0), bit'($urandom_range(0, 59) == 0),
           bit'($urandom_range(0, 2) != 0));
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
Parametrised serial pattern detector for a 1-bit input stream. It matches NUM_PAT fixed patterns of PAT_LEN bits each as a Mealy machine with registered outputs. Over a simple pattern detector it adds input enable, overlap/non-overlap mode, fill tracking so no false match can occur after reset or clear, and saturating per-pattern hit counters. It sits after a serial deserialiser or input sampler as a framing/marker detector.

Parameters:
PAT_LEN, 3, bits per pattern (>=2)
NUM_PAT, 2, number of patterns
PAT_VEC, {3'b111,3'b001}, PAT_LEN*NUM_PAT bits; pattern k = PAT_VEC[k*PAT_LEN +: PAT_LEN]; MSB of slice = oldest bit
OVERLAP, 1, 1 = matches may share bits; 0 = history discarded after any match
CNT_W, 8, width of each hit counter

Ports:
clock     in   1                 rising-edge clock
reset_n   in   1                 asynchronous active-low reset
en        in   1                 sample i on this edge
clr       in   1                 synchronous clear of history, fill and counters
i         in   1                 serial data bit
o         out  NUM_PAT           per-pattern match pulse, registered
any_match out  1                 OR of o, registered
hit_cnt   out  NUM_PAT*CNT_W     saturating hit counts, pattern k at [k*CNT_W +: CNT_W]
fill      out  clog2(PAT_LEN+1)  valid history bits, saturates at PAT_LEN-1

Behaviour:
- Reset (reset_n low, asynchronous): history=0, fill=0, o=0, any_match=0, all hit_cnt=0. Reset mid-stream discards partial history.
- Window = {history[PAT_LEN-2:0], i}; i is the newest bit (LSB).
- Pattern k matches on an edge when en=1, clr=0, fill==PAT_LEN-1, and window == pattern k.
- Latency: o[k] rises after the edge that samples the final pattern bit and stays high exactly one cycle unless the next edge matches again.
- o is cleared to 0 on every edge where there is no match, including en=0 and clr=1.
- en=0: history, fill and counters hold; o=0.
- en=1, no match: history shifts i in; fill increments, saturating at PAT_LEN-1.
- en=1, match, OVERLAP=1: history shifts normally; fill stays at PAT_LEN-1.
- en=1, match, OVERLAP=0: fill goes to 0, so the next match needs PAT_LEN fresh bits.
- Simultaneous matches (equal or overlapping patterns): all matching o bits assert in the same cycle; each matching counter increments.
- hit_cnt[k] increments by 1 per match and saturates at 2^CNT_W-1 (no wrap).
- clr=1: history=0, fill=0, counters=0, o=0. clr takes priority over en and over a match in the same cycle.
- No state machine beyond the fill counter. Mode is fixed by parameter. Logic is purely synchronous except reset.

Decomposition:
- Shared package: clog2 function, pattern-slice extraction function, OVERLAP mode constants.
- Sub-module sat_counter (params W; ports clock, reset_n, clr, inc, count). Instantiate NUM_PAT times in a generate loop.

Test Plan:
1. Default parameters; reset_n pulsed low mid-stream after bits 0,0 -> o=00, fill=0, hit_cnt=0 immediately; a following single 1 gives no match (fill too low).
2. After reset, i=0,0,1 with en=1 -> o=01 for one cycle after the 3rd edge; any_match=1; hit_cnt0=1; hit_cnt1=0.
3. OVERLAP=1, i=1,1,1,1,1 -> o[1] high after edges 3, 4 and 5; hit_cnt1=3. OVERLAP=0, same stream -> o[1] only after edge 3; a 6th 1 gives the 2nd hit; hit_cnt1=2.
4. i=0 (en=1), then en=0 for two cycles with i toggling, then en=1 with i=0,1 -> match of 001 on the last edge; o=0 during the en=0 cycles.
5. CNT_W=2, six 001 matches -> hit_cnt0 reaches 3 and holds at 3; then clr=1 with en=1 and a matching bit -> o=0, hit_cnt0=0, fill=0.
6. Duplicate patterns, PAT_VEC={3'b001,3'b001}, i=0,0,1 -> o=11, both counters=1, any_match=1.
